// File: rtl/bp_update_ctrl.sv
// BTB update controller: buffers resolved branches, flags mispredictions, and is the sole BTB writer.
// Optional build macro BP_NT_ALLOC_EN: allocate BTB entries on not-taken misses (dropped otherwise).
module bp_update_ctrl #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] PC_STEP    = 16'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [15:0] res_pc,
    input  logic [15:0] res_target,
    input  logic        res_taken,
    input  logic        res_pred_taken,
    input  logic [15:0] res_pred_target,
    input  logic [3:0]  bp_hit_idx,
    output logic [15:0] bp_pc_out,
    output logic [15:0] bp_bta_out,
    output logic        bp_hist_out,
    output logic [2:0]  bp_addr_out,
    output logic        bp_we,
    output logic        mispredict,
    output logic [15:0] redirect_pc,
    output logic        busy
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    logic [15:0]   fifo_pc    [FIFO_DEPTH];
    logic [15:0]   fifo_tgt   [FIFO_DEPTH];
    logic          fifo_taken [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [1:0]    state;
    logic [2:0]    tgt_idx_q;
    logic          alloc_q;
    logic [2:0]    repl_ptr;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic          hit;
    logic [2:0]    lookup_idx;
    logic [15:0]   head_pc;
    logic [15:0]   head_tgt;
    logic          head_taken;
    logic          mp_now;
    logic [15:0]   redir_now;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign res_ready  = !fifo_full;
    assign push       = res_valid && !fifo_full;

    assign head_pc    = fifo_pc[rd_ptr];
    assign head_tgt   = fifo_tgt[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];

    assign hit        = bp_hit_idx[3];
    assign lookup_idx = hit ? bp_hit_idx[2:0] : repl_ptr;

`ifdef BP_NT_ALLOC_EN
    assign drop = 1'b0;
`else
    // A not-taken branch that misses carries nothing worth caching.
    assign drop = (state == S_LOOKUP) && !hit && !head_taken;
`endif

    assign pop = (state == S_WRITE) || drop;

    // NOTE: FIFO storage is deliberately not reset; occupancy is tracked by count,
    // so stale entries are never observed and the array maps onto plain RAM/flops.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= res_pc;
            fifo_tgt[wr_ptr]   <= res_target;
            fifo_taken[wr_ptr] <= res_taken;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            tgt_idx_q <= '0;
            alloc_q   <= 1'b0;
            repl_ptr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    tgt_idx_q <= lookup_idx;
                    alloc_q   <= !hit;
                    state     <= drop ? S_IDLE : S_WRITE;
                end
                S_WRITE: begin
                    if (alloc_q) repl_ptr <= repl_ptr + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mp_now    = (res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target));
    assign redir_now = res_taken ? res_target : res_pc + PC_STEP;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= push && mp_now;
            if (push) redirect_pc <= redir_now;
        end
    end

    // Head fields stay put from LOOKUP through WRITE because the pop lands on the WRITE edge.
    assign bp_pc_out   = fifo_empty ? '0 : head_pc;
    assign bp_bta_out  = fifo_empty ? '0 : head_tgt;
    assign bp_hist_out = (state == S_WRITE) && head_taken;
    assign bp_addr_out = (state == S_LOOKUP) ? lookup_idx : tgt_idx_q;
    assign bp_we       = (state == S_WRITE);
    assign busy        = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed self-checking bench for bp_update_ctrl; BTB match results are driven by hand.
// Honours BP_NT_ALLOC_EN to choose the expected not-taken-miss behaviour.
module tb_bp_update_ctrl;

    logic        clock;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_pc;
    logic [15:0] res_target;
    logic        res_taken;
    logic        res_pred_taken;
    logic [15:0] res_pred_target;
    logic [3:0]  bp_hit_idx;
    logic [15:0] bp_pc_out;
    logic [15:0] bp_bta_out;
    logic        bp_hist_out;
    logic [2:0]  bp_addr_out;
    logic        bp_we;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic        busy;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] bta;
        logic        hist;
        logic [15:0] pc;
    } wr_t;

    localparam logic [55:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'h0, 1'b0};

    int          vectors;
    int          miscompares;
    wr_t         wq[$];
    logic [15:0] mq[$];

    bp_update_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_pc          (res_pc),
        .res_target      (res_target),
        .res_taken       (res_taken),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .bp_hit_idx      (bp_hit_idx),
        .bp_pc_out       (bp_pc_out),
        .bp_bta_out      (bp_bta_out),
        .bp_hist_out     (bp_hist_out),
        .bp_addr_out     (bp_addr_out),
        .bp_we           (bp_we),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (bp_we) wq.push_back('{addr: bp_addr_out, bta: bp_bta_out, hist: bp_hist_out, pc: bp_pc_out});
            if (mispredict) mq.push_back(redirect_pc);
        end
    end

    function automatic logic [55:0] out_vec();
        return {res_ready, busy, bp_we, mispredict, redirect_pc, bp_pc_out,
                bp_bta_out, bp_addr_out, bp_hist_out};
    endfunction

    task automatic send(input logic [15:0] pc, input logic [15:0] tgt, input logic tk,
                        input logic ptk, input logic [15:0] ptg);
        int n;
        n = 0;
        res_pc = pc; res_target = tgt; res_taken = tk;
        res_pred_taken = ptk; res_pred_target = ptg;
        res_valid = 1'b1;
        while (!res_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        res_valid = 1'b0;
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL send_timeout pc=%h: res_ready stayed low", pc);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        vectors++;
        if (out_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required %h", out_vec(), RESET_VEC);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (out_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL post_release_outputs: got %h required %h", out_vec(), RESET_VEC);
        end
    endtask

    task automatic test_first_miss();
        bp_hit_idx = 4'b0000;
        @(posedge clock); #1;
        res_pc = 16'h0010; res_target = 16'h0040; res_taken = 1'b1;
        res_pred_taken = 1'b0; res_pred_target = 16'h0000;
        res_valid = 1'b1;
        @(posedge clock); #1;
        res_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if ({mispredict, redirect_pc, bp_we} !== {1'b1, 16'h0040, 1'b0}) begin
            miscompares++;
            $display("FAIL first_mispredict: mp=%b redir=%h we=%b required 1 0040 0",
                     mispredict, redirect_pc, bp_we);
        end
        @(negedge clock);
        vectors++;
        if ({mispredict, bp_we, bp_addr_out, bp_pc_out} !== {1'b0, 1'b0, 3'd0, 16'h0010}) begin
            miscompares++;
            $display("FAIL first_lookup: mp=%b we=%b addr=%0d pc=%h required 0 0 0 0010",
                     mispredict, bp_we, bp_addr_out, bp_pc_out);
        end
        @(negedge clock);
        vectors++;
        if ({bp_we, bp_addr_out, bp_bta_out, bp_hist_out, bp_pc_out} !==
            {1'b1, 3'd0, 16'h0040, 1'b1, 16'h0010}) begin
            miscompares++;
            $display("FAIL first_write: we=%b addr=%0d bta=%h hist=%b pc=%h required 1 0 0040 1 0010",
                     bp_we, bp_addr_out, bp_bta_out, bp_hist_out, bp_pc_out);
        end
        @(negedge clock);
        vectors++;
        if ({bp_we, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL first_done: we=%b busy=%b required 0 0", bp_we, busy);
        end
    endtask

    task automatic test_hit_update();
        logic [15:0] exp_redir [3];
        wr_t         exp_wr    [3];
        exp_redir[0] = 16'h0011; exp_redir[1] = 16'h0060; exp_redir[2] = 16'h0000;
        exp_wr[0] = '{addr: 3'd0, bta: 16'h0040, hist: 1'b0, pc: 16'h0010};
        exp_wr[1] = '{addr: 3'd2, bta: 16'h0060, hist: 1'b1, pc: 16'h0050};
        exp_wr[2] = '{addr: 3'd3, bta: 16'h1234, hist: 1'b0, pc: 16'hFFFF};
        wq.delete(); mq.delete();
        bp_hit_idx = 4'b1000;
        send(16'h0010, 16'h0040, 1'b0, 1'b1, 16'h0040);
        wait_idle();
        bp_hit_idx = 4'b1010;
        send(16'h0050, 16'h0060, 1'b1, 1'b1, 16'h0070);
        wait_idle();
        bp_hit_idx = 4'b1011;
        send(16'hFFFF, 16'h1234, 1'b0, 1'b1, 16'h0000);
        wait_idle();
        bp_hit_idx = 4'b0000;
        vectors++;
        if (mq.size() != 3 || wq.size() != 3) begin
            miscompares++;
            $display("FAIL hit_counts: mispredicts=%0d writes=%0d required 3 3", mq.size(), wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (mq[i] !== exp_redir[i]) begin
                    miscompares++;
                    $display("FAIL hit_redirect[%0d]: got %h required %h", i, mq[i], exp_redir[i]);
                end
                vectors++;
                if (wq[i] !== exp_wr[i]) begin
                    miscompares++;
                    $display("FAIL hit_write[%0d]: got %h required %h", i, wq[i], exp_wr[i]);
                end
            end
        end
    endtask

    task automatic test_repl_wrap();
        wr_t exp;
        wq.delete(); mq.delete();
        bp_hit_idx = 4'b0000;
        for (int i = 0; i < 9; i++)
            send(16'h0100 + 16'(i), 16'h0200 + 16'(i), 1'b1, 1'b1, 16'h0200 + 16'(i));
        wait_idle();
        vectors++;
        if (wq.size() != 9 || mq.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_counts: writes=%0d mispredicts=%0d required 9 0", wq.size(), mq.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                exp = '{addr: 3'((i + 1) % 8), bta: 16'h0200 + 16'(i), hist: 1'b1, pc: 16'h0100 + 16'(i)};
                vectors++;
                if (wq[i] !== exp) begin
                    miscompares++;
                    $display("FAIL wrap_write[%0d]: got %h required %h", i, wq[i], exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   occ, k, max_occ;
        logic rdy, we;
        wr_t  exp;
        occ = 0; k = 0; max_occ = 0;
        wq.delete(); mq.delete();
        @(posedge clock); #1;
        res_pc = 16'h0400; res_target = 16'h0500; res_taken = 1'b1;
        res_pred_taken = 1'b1; res_pred_target = 16'h0500;
        res_valid = 1'b1;
        for (int c = 0; c < 80 && (k < 6 || occ > 0); c++) begin
            @(negedge clock);
            rdy = res_ready;
            we  = bp_we;
            vectors++;
            if (rdy !== (occ < 4)) begin
                miscompares++;
                $display("FAIL b2b_ready cycle %0d: got %b required %b (occupancy %0d)", c, rdy, occ < 4, occ);
            end
            @(posedge clock);
            if (res_valid && rdy) begin
                occ++;
                k++;
            end
            if (we) occ--;
            if (occ > max_occ) max_occ = occ;
            #1;
            if (k < 6) begin
                res_pc = 16'h0400 + 16'(k); res_target = 16'h0500 + 16'(k);
                res_pred_target = 16'h0500 + 16'(k);
            end else begin
                res_valid = 1'b0;
            end
        end
        res_valid = 1'b0;
        wait_idle();
        vectors++;
        if (max_occ != 4 || k != 6) begin
            miscompares++;
            $display("FAIL b2b_fill: peak occupancy=%0d accepted=%0d required 4 6", max_occ, k);
        end
        vectors++;
        if (wq.size() != 6) begin
            miscompares++;
            $display("FAIL b2b_writes: got %0d required 6", wq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp = '{addr: 3'((2 + i) % 8), bta: 16'h0500 + 16'(i), hist: 1'b1, pc: 16'h0400 + 16'(i)};
                vectors++;
                if (wq[i] !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_write[%0d]: got %h required %h", i, wq[i], exp);
                end
            end
        end
    endtask

    task automatic test_reset_in_write();
        int n;
        bp_hit_idx = 4'b0000;
        send(16'h02F0, 16'h02F8, 1'b1, 1'b1, 16'h02F8);
        wait_idle();
        send(16'h0300, 16'h0333, 1'b1, 1'b0, 16'h0000);
        n = 0;
        @(negedge clock);
        while (!bp_we && n < 20) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (!bp_we || bp_addr_out !== 3'd1) begin
            miscompares++;
            $display("FAIL rst_pre_write: we=%b addr=%0d required 1 1", bp_we, bp_addr_out);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (out_vec() !== RESET_VEC) begin
            miscompares++;
            $display("FAIL rst_async_outputs: got %h required %h", out_vec(), RESET_VEC);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        wq.delete(); mq.delete();
        repeat (10) @(negedge clock);
        vectors++;
        if (wq.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_resume: writes=%0d busy=%b required 0 0", wq.size(), busy);
        end
        send(16'h0310, 16'h0311, 1'b1, 1'b1, 16'h0311);
        wait_idle();
        vectors++;
        if (wq.size() != 1 || wq[0].addr !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_repl_ptr: writes=%0d addr=%0d required 1 0", wq.size(),
                     wq.size() > 0 ? wq[0].addr : 3'd7);
        end
    endtask

    task automatic test_nt_miss();
        logic [2:0] exp_next;
        wq.delete(); mq.delete();
        bp_hit_idx = 4'b0000;
        send(16'h0020, 16'h0080, 1'b0, 1'b0, 16'h0000);
        wait_idle();
        vectors++;
        if (mq.size() != 0) begin
            miscompares++;
            $display("FAIL nt_mispredict: pulses=%0d required 0", mq.size());
        end
`ifdef BP_NT_ALLOC_EN
        exp_next = 3'd2;
        vectors++;
        if (wq.size() != 1 || wq[0] !== wr_t'{addr: 3'd1, bta: 16'h0080, hist: 1'b0, pc: 16'h0020}) begin
            miscompares++;
            $display("FAIL nt_alloc: writes=%0d first=%h required 1 write to entry 1 hist 0",
                     wq.size(), wq.size() > 0 ? wq[0] : wr_t'('0));
        end
`else
        exp_next = 3'd1;
        vectors++;
        if (wq.size() != 0) begin
            miscompares++;
            $display("FAIL nt_drop: writes=%0d required 0", wq.size());
        end
`endif
        wq.delete();
        send(16'h0024, 16'h0090, 1'b1, 1'b1, 16'h0090);
        wait_idle();
        vectors++;
        if (wq.size() != 1 || wq[0].addr !== exp_next) begin
            miscompares++;
            $display("FAIL nt_repl_after: writes=%0d addr=%0d required 1 %0d", wq.size(),
                     wq.size() > 0 ? wq[0].addr : 3'd7, exp_next);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        res_valid = 1'b0;
        res_pc = '0; res_target = '0; res_taken = 1'b0;
        res_pred_taken = 1'b0; res_pred_target = '0;
        bp_hit_idx = 4'b0000;
        test_reset();
        test_first_miss();
        test_hit_update();
        test_repl_wrap();
        test_back_to_back();
        test_reset_in_write();
        test_nt_miss();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Update controller for the 8-entry branch target buffer. Accepts resolved-branch records from the execute stage and flags mispredictions with a redirect PC. Buffers the records in a small FIFO. Sequences each record through a BTB lookup and a single-cycle BTB write, allocating entries round-robin on a miss. It owns every BTB write-side signal, so the BTB has exactly one writer.

## Interface
- FIFO_DEPTH, 4, resolved-branch buffer depth; power of two, at least 2
- PC_STEP, 16'd1, fall-through increment used for the not-taken redirect PC
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- res_valid  in  1  resolved-branch record valid
- res_ready  out  1  controller can accept a record
- res_pc  in  16  PC of the resolved branch
- res_target  in  16  computed branch target
- res_taken  in  1  actual outcome
- res_pred_taken  in  1  history bit predicted at fetch
- res_pred_target  in  16  BTA predicted at fetch
- bp_hit_idx  in  4  BTB match result for bp_pc_out: bit 3 = hit, bits 2:0 = entry index
- bp_pc_out  out  16  PC driven to the BTB write-side compare and PC field
- bp_bta_out  out  16  BTA to write
- bp_hist_out  out  1  history bit to write
- bp_addr_out  out  3  BTB entry to write
- bp_we  out  1  BTB write enable, one-cycle pulse
- mispredict  out  1  one-cycle pulse, front end must flush and redirect
- redirect_pc  out  16  correct next PC, valid while mispredict=1
- busy  out  1  FIFO non-empty or FSM not in IDLE

## Operation
- **Handshake:** a record is accepted on a rising edge with res_valid && res_ready. res_ready = !fifo_full, with no same-cycle bypass at full.
- **Misprediction check:** performed on each accepted record, registered, so mispredict appears the cycle after acceptance.
  - mispredict = (res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target).
  - redirect_pc = res_taken ? res_target : res_pc + PC_STEP, modulo 2^16.
- **FSM states:** IDLE, LOOKUP, WRITE.
- **IDLE:** bp_pc_out = FIFO head PC. If the FIFO is non-empty, go to LOOKUP.
- **LOOKUP:** sample bp_hit_idx.
  - Hit: target index = bp_hit_idx[2:0], alloc = 0.
  - Miss: target index = repl_ptr, alloc = 1.
  - Miss with head.taken = 0 and BP_NT_ALLOC_EN undefined: pop head, go to IDLE, no write.
  - Otherwise go to WRITE.
- **WRITE:** bp_we = 1 with bp_addr_out = target index, bp_bta_out = head.target, bp_hist_out = head.taken.
  - Pop the head.
  - If alloc, repl_ptr <= repl_ptr + 1 (wraps 7 -> 0).
  - Return to IDLE.
- **Stable outputs:** bp_pc_out, bp_bta_out and bp_addr_out hold from LOOKUP through WRITE.
- **Duplicate PCs:** a record for the same PC queued behind another sees the completed write, because the BTB write lands on the WRITE edge, before the next LOOKUP. No duplicate entries are allocated.
- **Hit index:** used as reported. An unwritten entry whose stored PC is 0 matching PC 0 counts as a hit.

## Timing
- **Reset values** (async assert, sync release): FSM = IDLE, FIFO empty, repl_ptr = 0, bp_we = 0, mispredict = 0, redirect_pc = 0, bp_pc_out/bp_bta_out = 0, bp_addr_out = 0, bp_hist_out = 0, res_ready = 1, busy = 0.
- **Reset mid-operation:** any pending write is aborted, and bp_we drops immediately.
- **Throughput:** one BTB update per 3 cycles (IDLE, LOOKUP, WRITE). A dropped not-taken miss costs 2 cycles.
- **Latency:** accept at edge N gives mispredict at N+1. With an empty FIFO, bp_we is high in cycle N+2.
- **Simultaneous push and pop:** allowed when not full, and occupancy is unchanged.
- **Back-to-back resolves:** the FIFO absorbs up to FIFO_DEPTH records. res_ready is low while full and rises the cycle after a pop.
- **mispredict:** never asserted for two cycles from one record. Consecutive accepted records may produce consecutive pulses.

## Configuration
- BP_NT_ALLOC_EN defined: BTB misses with taken = 0 are allocated, with H = 0 and the BTA written.
- BP_NT_ALLOC_EN undefined: such records are dropped after LOOKUP and repl_ptr is unchanged.
- Hit updates and misprediction reporting are identical in both builds.

## Test plan
- Reset, then one record (pc=0x0010, target=0x0040, taken=1, pred_taken=0), BTB miss:
  - mispredict=1 with redirect_pc=0x0040 the next cycle.
  - bp_we at N+2 with addr=0, bta=0x0040, hist=1; repl_ptr then 1.
- Same PC again with taken=0 and pred_taken=1, bp_hit_idx=4'b1000:
  - mispredict with redirect_pc=0x0011.
  - Write to entry 0 with hist=0; repl_ptr stays 1.
- Nine distinct taken misses:
  - Writes go to entries 1..7, then 0, then 1 (pointer wrap).
- Hold res_valid high for 6 records while lookups stall the FIFO:
  - res_ready low after 4 accepted, then one acceptance per pop.
  - All 6 records write in order.
- Assert reset during WRITE:
  - bp_we falls asynchronously and all outputs take their reset values.
  - No record is resumed after release.
- Not-taken miss (pc=0x0020, taken=0, pred_taken=0):
  - No mispredict in either build.
  - With BP_NT_ALLOC_EN: write with hist=0.
  - Without BP_NT_ALLOC_EN: no bp_we pulse, repl_ptr unchanged.
